// File: rtl/frame_loader.sv
// frame_loader: parses framed GRB pixel packets (header, 3*DATA_NUM payload
// bytes, XOR checksum) from a byte stream into a shadow buffer. A frame whose
// checksum matches is copied to data[] in one cycle while ready is pulled low
// for LOW_CYCLES cycles, so the downstream LED stage restarts on the new frame.
module frame_loader #(
    parameter int         DATA_NUM   = 32,
    parameter logic [7:0] HDR_BYTE   = 8'hA5,
    parameter int         TIMEOUT    = 4096,
    parameter int         LOW_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic [DATA_NUM-1:0][23:0] data,
    output logic                      ready,
    output logic                      frame_err,
    output logic [7:0]                frame_cnt
);

    localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam int LOW_W = (LOW_CYCLES > 1) ? $clog2(LOW_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    // Running XOR checksum of the payload bytes.
    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Places one byte into its colour lane: 0=G [23:16], 1=R [15:8], 2=B [7:0].
    function automatic logic [23:0] lane_write(input logic [23:0] pix,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [23:0] res;
        res = pix;
        case (lane)
            2'd0:    res[23:16] = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[7:0]   = b;
            default: res        = pix;
        endcase
        return res;
    endfunction

    state_t                    state_r;
    state_t                    state_s;
    logic                      xfer_s;
    logic                      hdr_hit_s;
    logic                      pay_wr_s;
    logic                      chk_wr_s;
    logic                      timeout_s;
    logic                      chk_bad_s;
    logic                      commit_s;
    logic                      release_s;

    logic [DATA_NUM-1:0][23:0] shadow_r;
    logic [DATA_NUM-1:0][23:0] data_r;
    logic [IDX_W-1:0]          idx_r;
    logic [1:0]                phase_r;
    logic                      await_chk_r;
    logic [7:0]                xor_r;
    logic [7:0]                chk_r;
    logic [GAP_W-1:0]          gap_r;
    logic [LOW_W-1:0]          low_cnt_r;
    logic                      byte_ready_r;
    logic                      ready_r;
    logic                      frame_err_r;
    logic [7:0]                frame_cnt_r;

    assign xfer_s     = byte_valid & byte_ready_r;
    assign byte_ready = byte_ready_r;
    assign data       = data_r;
    assign ready      = ready_r;
    assign frame_err  = frame_err_r;
    assign frame_cnt  = frame_cnt_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and single-cycle datapath strobes.
    always_comb begin
        state_s   = state_r;
        hdr_hit_s = 1'b0;
        pay_wr_s  = 1'b0;
        chk_wr_s  = 1'b0;
        timeout_s = 1'b0;
        chk_bad_s = 1'b0;
        commit_s  = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && (byte_in == HDR_BYTE)) begin
                    hdr_hit_s = 1'b1;
                    state_s   = ST_PAYLOAD;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (xfer_s) begin
                    if (await_chk_r) begin
                        chk_wr_s = 1'b1;
                        state_s  = ST_CHECK;
                    end else begin
                        pay_wr_s = 1'b1;
                        state_s  = ST_PAYLOAD;
                    end
                end else if (gap_r == GAP_W'(TIMEOUT)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (chk_r == xor_r) begin
                    commit_s  = 1'b1;
                    state_s   = ST_COMMIT;
                end else begin
                    chk_bad_s = 1'b1;
                    state_s   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (low_cnt_r == LOW_W'(LOW_CYCLES - 1)) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_COMMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Payload parser: header clears the running state, payload bytes fill the shadow buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r    <= '0;
            idx_r       <= '0;
            phase_r     <= 2'd0;
            await_chk_r <= 1'b0;
            xor_r       <= 8'h00;
            chk_r       <= 8'h00;
        end else if (hdr_hit_s) begin
            idx_r       <= '0;
            phase_r     <= 2'd0;
            await_chk_r <= 1'b0;
            xor_r       <= 8'h00;
        end else if (pay_wr_s) begin
            shadow_r[idx_r] <= lane_write(shadow_r[idx_r], phase_r, byte_in);
            xor_r           <= xor_accum(xor_r, byte_in);
            if (phase_r == 2'd2) begin
                phase_r <= 2'd0;
                if (idx_r == IDX_W'(DATA_NUM - 1)) begin
                    await_chk_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                phase_r <= phase_r + 2'd1;
            end
        end else if (chk_wr_s) begin
            chk_r <= byte_in;
        end
    end

    // Inter-byte gap counter, saturating; only advances while waiting for payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_r <= '0;
        end else if (hdr_hit_s || pay_wr_s || chk_wr_s) begin
            gap_r <= '0;
        end else if ((state_r == ST_PAYLOAD) && (gap_r != GAP_MAX)) begin
            gap_r <= gap_r + GAP_W'(1);
        end else begin
            gap_r <= gap_r;
        end
    end

    // Counts the cycles ready is held low after a commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_cnt_r <= '0;
        end else if (commit_s) begin
            low_cnt_r <= '0;
        end else if (state_r == ST_COMMIT) begin
            low_cnt_r <= low_cnt_r + LOW_W'(1);
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    // Registered outputs: handshake, error pulse, commit of all pixels at once, restart pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready_r <= 1'b0;
            frame_err_r  <= 1'b0;
            ready_r      <= 1'b0;
            frame_cnt_r  <= 8'd0;
            data_r       <= '0;
        end else begin
            byte_ready_r <= (state_s == ST_IDLE) || (state_s == ST_PAYLOAD);
            frame_err_r  <= timeout_s | chk_bad_s;
            if (commit_s) begin
                data_r      <= shadow_r;
                ready_r     <= 1'b0;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else if (release_s) begin
                ready_r     <= 1'b1;
            end else begin
                ready_r     <= ready_r;
            end
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: the driver pushes the expected outcome of
// every frame it sends (commit with pixel image and count, or error), and an
// independent monitor compares DUT events against the queue as they appear.
module tb_frame_loader;

    localparam int         DATA_NUM   = 32;
    localparam int         PAY_N      = 3 * DATA_NUM;
    localparam logic [7:0] HDR        = 8'hA5;
    localparam int         TIMEOUT    = 4096;
    localparam int         LOW_CYCLES = 4;

    logic                      clk        = 1'b0;
    logic                      rst        = 1'b0;
    logic [7:0]                byte_in    = 8'h00;
    logic                      byte_valid = 1'b0;
    logic                      byte_ready;
    logic [DATA_NUM-1:0][23:0] data;
    logic                      ready;
    logic                      frame_err;
    logic [7:0]                frame_cnt;

    frame_loader #(
        .DATA_NUM  (DATA_NUM),
        .HDR_BYTE  (HDR),
        .TIMEOUT   (TIMEOUT),
        .LOW_CYCLES(LOW_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .data      (data),
        .ready     (ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                        is_err;
        logic [7:0]                cnt;
        logic [DATA_NUM-1:0][23:0] pix;
        logic                      rdy;
        int                        cyc;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    logic [DATA_NUM-1:0][23:0] model_data  = '0;
    logic [7:0]                model_cnt   = 8'd0;
    logic                      model_ready = 1'b0;
    logic [DATA_NUM-1:0][23:0] zero_img    = '0;
    logic [7:0]                pay_buf [PAY_N];
    int                        last_xfer_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_img(input string name, input logic [DATA_NUM-1:0][23:0] act,
                             input logic [DATA_NUM-1:0][23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            for (int p = 0; p < DATA_NUM; p++) begin
                if (act[p] !== exp[p]) begin
                    $display("FAIL %s: pixel %0d got %06h, expected %06h (cycle %0d)",
                             name, p, act[p], exp[p], cyc);
                    break;
                end
            end
        end
    endtask

    // Present one byte and hold it until the loader accepts it.
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 64) begin
            tests++;
            fails++;
            $display("FAIL byte_accept: byte_ready=%b, expected 1 within 64 cycles", byte_ready);
        end
        last_xfer_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    // Send header + pay_buf + checksum; record what the loader must do with it.
    task automatic send_frame(input bit corrupt, input int gap_max, input int hdr_wait_exp);
        int         w;
        logic [7:0] x;
        exp_t       e;
        send_byte(HDR, w);
        if (hdr_wait_exp >= 0) check("hdr_wait_ready_low", w, hdr_wait_exp);
        x = 8'h00;
        for (int i = 0; i < PAY_N; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send_byte(pay_buf[i], w);
            x = x ^ pay_buf[i];
        end
        send_byte(corrupt ? (x ^ 8'h01) : x, w);
        e.cyc = last_xfer_cyc + 1;
        if (!corrupt) begin
            for (int p = 0; p < DATA_NUM; p++)
                model_data[p] = {pay_buf[3*p], pay_buf[3*p+1], pay_buf[3*p+2]};
            model_cnt = model_cnt + 8'd1;
            e.is_err  = 1'b0;
            e.rdy     = 1'b0;
        end else begin
            e.is_err  = 1'b1;
            e.rdy     = model_ready;
        end
        e.cnt = model_cnt;
        e.pix = model_data;
        exp_q.push_back(e);
        if (!corrupt) model_ready = 1'b1;
    endtask

    task automatic fill_ascending();
        for (int i = 0; i < PAY_N; i++) pay_buf[i] = 8'(i + 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < PAY_N; i++) pay_buf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        check("queue_drained_before_reset", exp_q.size(), 0);
        @(negedge clk);
        #2;
        rst         = 1'b0;
        byte_valid  = 1'b0;
        model_data  = '0;
        model_cnt   = 8'd0;
        model_ready = 1'b0;
        #1;
        check("rst_byte_ready", byte_ready, 0);
        check("rst_ready", ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check_img("rst_data", data, zero_img);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("byte_ready_after_release", byte_ready, 1);
    endtask

    // Monitor: pops an expectation on every commit or error the DUT shows.
    initial begin : monitor
        exp_t                      e;
        logic [7:0]                prev_cnt;
        logic                      prev_ready;
        logic                      prev_err;
        logic [DATA_NUM-1:0][23:0] prev_data;
        int                        pend_rise;
        prev_cnt = 8'd0; prev_ready = 1'b0; prev_err = 1'b0; prev_data = '0; pend_rise = -1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (frame_err === 1'b1 && prev_err === 1'b1) begin
                    check("frame_err_one_cycle", prev_err, 0);
                end else if (frame_err === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_frame_err: got frame_err=1 at cycle %0d, expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("err_event_kind", e.is_err, 1);
                        check("err_cycle", cyc, e.cyc);
                        check("err_ready_kept", ready, e.rdy);
                        check("err_frame_cnt", frame_cnt, e.cnt);
                        check_img("err_data_kept", data, e.pix);
                    end
                end
                if (frame_cnt !== prev_cnt) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_commit: frame_cnt=%0d at cycle %0d, expected none", frame_cnt, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_event_kind", e.is_err, 0);
                        check("commit_cycle", cyc, e.cyc);
                        check("commit_frame_cnt", frame_cnt, e.cnt);
                        check("commit_ready_low", ready, 0);
                        check_img("commit_data", data, e.pix);
                        pend_rise = e.cyc + LOW_CYCLES;
                    end
                end else if (data !== prev_data) begin
                    tests++; fails++;
                    $display("FAIL data_changed_without_commit: data changed at cycle %0d, expected stable", cyc);
                end
                if (ready === 1'b1 && prev_ready !== 1'b1) begin
                    check("ready_rise_cycle", cyc, pend_rise);
                    pend_rise = -1;
                end
            end else begin
                pend_rise = -1;
            end
            prev_cnt   = frame_cnt;
            prev_ready = ready;
            prev_err   = frame_err;
            prev_data  = data;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   w;
        exp_t e;

        // 1: ascending frame commits
        do_reset();
        fill_ascending();
        send_frame(1'b0, 0, -1);
        idle(LOW_CYCLES + 6);
        check("t1_pixel0", data[0], 24'h010203);
        check("t1_pixel_last", data[DATA_NUM-1], 24'h5E5F60);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_ready_high", ready, 1);

        // 2: bad checksum
        do_reset();
        fill_ascending();
        send_frame(1'b1, 0, -1);
        idle(LOW_CYCLES + 6);
        check_img("t2_data_zero", data, zero_img);
        check("t2_ready_low", ready, 0);
        check("t2_frame_cnt", frame_cnt, 0);

        // 3: garbage then frame with header byte inside the payload
        send_byte(8'h00, w);
        send_byte(8'hFF, w);
        send_byte(8'h13, w);
        fill_random();
        pay_buf[7] = HDR;
        send_frame(1'b0, 3, -1);
        idle(LOW_CYCLES + 6);
        check("t3_payload_hdr_byte", data[2][15:8], HDR);
        check("t3_frame_cnt", frame_cnt, 1);

        // 4: partial frame then silence until timeout, then a good frame
        send_byte(HDR, w);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), w);
        e.is_err = 1'b1;
        e.cyc    = last_xfer_cyc + TIMEOUT + 1;
        e.cnt    = model_cnt;
        e.pix    = model_data;
        e.rdy    = model_ready;
        exp_q.push_back(e);
        idle(TIMEOUT + 20);
        check("t4_timeout_reported", exp_q.size(), 0);
        fill_random();
        send_frame(1'b0, 1, -1);
        idle(LOW_CYCLES + 6);
        check("t4_pixel0", data[0], {pay_buf[0], pay_buf[1], pay_buf[2]});

        // 5: back-to-back frames with byte_valid held high
        do_reset();
        fill_random();
        send_frame(1'b0, 0, -1);
        fill_random();
        send_frame(1'b0, 0, 1 + LOW_CYCLES);
        idle(LOW_CYCLES + 6);
        check("t5_frame_cnt", frame_cnt, 2);

        // 6: reset mid-payload, then 256 commits wrap the counter
        send_byte(HDR, w);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), w);
        do_reset();
        fill_random();
        send_frame(1'b0, 0, -1);
        idle(LOW_CYCLES + 6);
        check_img("t6_only_new_frame", data, model_data);
        check("t6_frame_cnt_one", frame_cnt, 1);
        for (int k = 1; k < 256; k++) begin
            fill_random();
            send_frame(1'b0, (k % 32 == 0) ? 2 : 0, -1);
        end
        idle(LOW_CYCLES + 6);
        check("t6_frame_cnt_wrap", frame_cnt, 0);
        check_img("t6_last_frame", data, model_data);

        idle(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
